// File: rtl/intr_pkg.sv
// rtl/intr_pkg.sv - shared constants and types for the interrupt capture front end
package intr_pkg;

    localparam int NUM_INTR_DEF = 16;

    localparam logic [2:0] ADDR_MODE = 3'd0;
    localparam logic [2:0] ADDR_MASK = 3'd1;
    localparam logic [2:0] ADDR_PEND = 3'd2;
    localparam logic [2:0] ADDR_CLR  = 3'd3;
    localparam logic [2:0] ADDR_SET  = 3'd4;
    localparam logic [2:0] ADDR_RAW  = 3'd5;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_ACCESS = 1'b1
    } apb_state_t;

endpackage

// File: rtl/intr_sync.sv
// rtl/intr_sync.sv - vector multi-flop synchroniser with async active-high reset
module intr_sync #(
    parameter int WIDTH  = 16,
    parameter int STAGES = 2
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    logic [STAGES-1:0][WIDTH-1:0] r_stage;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_stage <= '0;
        end else begin
            r_stage <= {r_stage[STAGES-2:0], i_d};
        end
    end

    assign o_q = r_stage[STAGES-1];

endmodule

// File: rtl/intr_capture.sv
// rtl/intr_capture.sv - interrupt line capture: sync, edge/level pending, mask, APB slave
module intr_capture
    import intr_pkg::*;
#(
    parameter int NUM_INTR    = NUM_INTR_DEF,
    parameter int WIDTH       = $clog2(NUM_INTR),
    parameter int SYNC_STAGES = 2
) (
    input  logic                pclk_i,
    input  logic                prst_i,
    input  logic                psel_i,
    input  logic                penable_i,
    input  logic                pwrite_i,
    input  logic [2:0]          paddr_i,
    input  logic [NUM_INTR-1:0] pwdata_i,
    output logic [NUM_INTR-1:0] prdata_o,
    output logic                pready_o,
    output logic                pslverr_o,
    input  logic [NUM_INTR-1:0] irq_raw_i,
    output logic [NUM_INTR-1:0] intr_active_o,
    input  logic [WIDTH-1:0]    intr_to_service_i,
    input  logic                intr_serviced_i
);

    apb_state_t          r_state;
    logic                r_pready;
    logic [NUM_INTR-1:0] r_mode;
    logic [NUM_INTR-1:0] r_mask;
    logic [NUM_INTR-1:0] r_pend;
    logic [NUM_INTR-1:0] r_active;
    logic [NUM_INTR-1:0] r_s_d;

    logic [NUM_INTR-1:0] w_s;
    logic [NUM_INTR-1:0] w_svc;
    logic [NUM_INTR-1:0] w_set;
    logic [NUM_INTR-1:0] w_clr;
    logic [NUM_INTR-1:0] w_pend_next;
    logic [NUM_INTR-1:0] w_rdata;
    logic                w_err;
    logic                w_commit;

    intr_sync #(
        .WIDTH  (NUM_INTR),
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .i_clk (pclk_i),
        .i_rst (prst_i),
        .i_d   (irq_raw_i),
        .o_q   (w_s)
    );

    always_ff @(posedge pclk_i or posedge prst_i) begin
        if (prst_i) begin
            r_state  <= ST_IDLE;
            r_pready <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (psel_i && penable_i) begin
                        r_state  <= ST_ACCESS;
                        r_pready <= 1'b1;
                    end
                end
                ST_ACCESS: begin
                    r_state  <= ST_IDLE;
                    r_pready <= 1'b0;
                end
            endcase
        end
    end

    assign w_commit = (r_state == ST_ACCESS) && psel_i && pwrite_i;

    // Out-of-range service indices simply match no line.
    always_comb begin
        w_svc = '0;
        for (int i = 0; i < NUM_INTR; i++) begin
            w_svc[i] = intr_serviced_i && (intr_to_service_i == WIDTH'(i));
        end
    end

    assign w_set = (w_s & ~r_s_d)
                 | ((w_commit && paddr_i == ADDR_SET) ? pwdata_i : '0);
    assign w_clr = w_svc
                 | ((w_commit && paddr_i == ADDR_CLR) ? pwdata_i : '0);

    // Set beats clear on edge lines; level lines just track the synchronised input.
    assign w_pend_next = (r_mode & (w_set | (r_pend & ~w_clr))) | (~r_mode & w_s);

    always_ff @(posedge pclk_i or posedge prst_i) begin
        if (prst_i) begin
            r_mode   <= '0;
            r_mask   <= '0;
            r_pend   <= '0;
            r_active <= '0;
            r_s_d    <= '0;
        end else begin
            r_s_d    <= w_s;
            r_pend   <= w_pend_next;
            r_active <= r_pend & r_mask;
            if (w_commit && paddr_i == ADDR_MODE) begin
                r_mode <= pwdata_i;
            end
            if (w_commit && paddr_i == ADDR_MASK) begin
                r_mask <= pwdata_i;
            end
        end
    end

    always_comb begin
        w_rdata = '0;
        w_err   = 1'b0;
        if (r_pready) begin
            case (paddr_i)
                ADDR_MODE: w_rdata = r_mode;
                ADDR_MASK: w_rdata = r_mask;
                ADDR_PEND: w_rdata = r_pend;
                ADDR_CLR:  w_rdata = '0;
                ADDR_SET:  w_rdata = '0;
                ADDR_RAW:  w_rdata = w_s;
                default:   w_err   = 1'b1;
            endcase
        end
    end

    assign prdata_o      = w_rdata;
    assign pslverr_o     = w_err;
    assign pready_o      = r_pready;
    assign intr_active_o = r_active;

endmodule

// File: tb/tb_intr_capture.sv
// tb/tb_intr_capture.sv - randomized scoreboard bench for intr_capture
module tb_intr_capture;

    localparam int N    = 16;
    localparam int SYNC = 2;

    typedef struct {
        logic [N-1:0] data;
        logic         err;
        logic         chk_data;
    } rd_t;

    logic         pclk = 1'b0;
    logic         prst = 1'b1;
    logic         psel = 1'b0;
    logic         penable = 1'b0;
    logic         pwrite = 1'b0;
    logic [2:0]   paddr = 3'd0;
    logic [N-1:0] pwdata = '0;
    logic [N-1:0] prdata;
    logic         pready;
    logic         pslverr;
    logic [N-1:0] irq_raw = '0;
    logic [N-1:0] intr_active;
    logic [3:0]   to_service = 4'd0;
    logic         serviced = 1'b0;

    int total = 0;
    int bad   = 0;

    logic [N-1:0] m_mode, m_mask, m_pend;
    logic [N-1:0] hist[$];
    logic [N-1:0] act_q[$];
    rd_t          rd_q[$];
    logic         mw_valid;
    logic [2:0]   mw_addr;
    logic [N-1:0] mw_data;
    logic         rand_en = 1'b0;
    int           rk;

    intr_capture dut (
        .pclk_i            (pclk),
        .prst_i            (prst),
        .psel_i            (psel),
        .penable_i         (penable),
        .pwrite_i          (pwrite),
        .paddr_i           (paddr),
        .pwdata_i          (pwdata),
        .prdata_o          (prdata),
        .pready_o          (pready),
        .pslverr_o         (pslverr),
        .irq_raw_i         (irq_raw),
        .intr_active_o     (intr_active),
        .intr_to_service_i (to_service),
        .intr_serviced_i   (serviced)
    );

    always #5 pclk = ~pclk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic m_clear();
        m_mode = '0;
        m_mask = '0;
        m_pend = '0;
        mw_valid = 1'b0;
        hist.delete();
        for (int i = 0; i <= SYNC; i++) hist.push_back('0);
        act_q.delete();
        rd_q.delete();
    endtask

    function automatic logic [N-1:0] m_read(input logic [2:0] a);
        case (a)
            3'd0:    return m_mode;
            3'd1:    return m_mask;
            3'd2:    return m_pend;
            3'd5:    return hist[SYNC-1];
            default: return '0;
        endcase
    endfunction

    // Reference model: hist[0] is the raw value sampled at the most recent edge.
    always @(posedge pclk) begin
        logic [N-1:0] s, sd, p, wset, wclr;
        if (prst) begin
            m_clear();
        end else begin
            s    = hist[SYNC-1];
            sd   = hist[SYNC];
            wset = (mw_valid && mw_addr == 3'd4) ? mw_data : '0;
            wclr = (mw_valid && mw_addr == 3'd3) ? mw_data : '0;
            act_q.push_back(m_pend & m_mask);
            p = m_pend;
            for (int i = 0; i < N; i++) begin
                if (!m_mode[i]) p[i] = s[i];
                else if ((s[i] && !sd[i]) || wset[i]) p[i] = 1'b1;
                else if ((serviced && int'(to_service) == i) || wclr[i]) p[i] = 1'b0;
            end
            if (mw_valid && mw_addr == 3'd0) m_mode = mw_data;
            if (mw_valid && mw_addr == 3'd1) m_mask = mw_data;
            m_pend = p;
            hist.push_front(irq_raw);
            void'(hist.pop_back());
            mw_valid = 1'b0;
        end
    end

    always @(negedge pclk) begin
        rd_t r;
        if (!prst) begin
            if (act_q.size() > 0) chk("active", intr_active, act_q.pop_front());
            if (pready) begin
                if (rd_q.size() == 0) begin
                    chk("pready_extra", 1, 0);
                end else begin
                    r = rd_q.pop_front();
                    if (r.chk_data) chk("prdata", prdata, r.data);
                    chk("pslverr", pslverr, r.err);
                end
            end else begin
                chk("idle_rd", {pslverr, prdata}, 0);
            end
        end
    end

    always @(posedge pclk) begin
        if (rand_en) begin
            #1;
            if ($urandom_range(0, 3) == 0) begin
                rk = $urandom_range(0, N - 1);
                irq_raw[rk] = ~irq_raw[rk];
            end
            serviced   = ($urandom_range(0, 5) == 0);
            to_service = 4'($urandom_range(0, 15));
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge pclk);
            #1;
        end
    endtask

    task automatic apb(input logic wr, input logic [2:0] a, input logic [N-1:0] d);
        rd_t r;
        psel = 1'b1; penable = 1'b1; pwrite = wr; paddr = a; pwdata = d;
        tick(1);
        r.data = m_read(a);
        r.err = (a > 3'd5);
        r.chk_data = !wr;
        rd_q.push_back(r);
        if (wr) begin
            mw_valid = 1'b1; mw_addr = a; mw_data = d;
        end
        tick(1);
        psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
        chk("pready_seen", rd_q.size(), 0);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        m_clear();
        #1;
        chk("rst_pready", pready, 0);
        chk("rst_active", intr_active, 0);
        chk("rst_prdata", prdata, 0);
        tick(2);
        prst = 1'b0;
        tick(1);

        // register read-back and bad address
        apb(1, 3'd0, 16'hFFFF);
        apb(1, 3'd1, 16'h00F0);
        apb(0, 3'd0, 0);
        apb(0, 3'd1, 0);
        apb(0, 3'd7, 0);

        // edge capture latency on line 5
        apb(1, 3'd1, 16'hFFFF);
        irq_raw[5] = 1'b1;
        tick(3);
        chk("lat_before", intr_active, 0);
        irq_raw[5] = 1'b0;
        tick(1);
        chk("lat_at4", intr_active, 16'h0020);
        tick(4);
        chk("edge_held", intr_active, 16'h0020);

        // service clear, then service colliding with a new edge
        to_service = 4'd5; serviced = 1'b1;
        tick(1);
        serviced = 1'b0;
        tick(1);
        chk("svc_clear", intr_active, 0);
        apb(0, 3'd2, 0);
        irq_raw[5] = 1'b1; tick(4); irq_raw[5] = 1'b0; tick(4);
        irq_raw[5] = 1'b1;
        tick(2);
        serviced = 1'b1;
        tick(1);
        serviced = 1'b0;
        tick(1);
        chk("set_wins", intr_active, 16'h0020);
        irq_raw[5] = 1'b0;
        apb(1, 3'd3, 16'hFFFF);

        // level mode on line 3
        apb(1, 3'd0, 16'h0000);
        apb(1, 3'd1, 16'h0008);
        irq_raw[3] = 1'b1;
        tick(5);
        chk("level_on", intr_active, 16'h0008);
        to_service = 4'd3; serviced = 1'b1;
        tick(1);
        serviced = 1'b0;
        tick(1);
        chk("level_svc", intr_active, 16'h0008);
        irq_raw[3] = 1'b0;
        tick(4);
        chk("level_off", intr_active, 0);

        // masking and software set/clear
        apb(1, 3'd0, 16'hFFFF);
        apb(1, 3'd1, 16'h0000);
        irq_raw[2] = 1'b1; tick(3); irq_raw[2] = 1'b0; tick(3);
        chk("masked", intr_active, 0);
        apb(0, 3'd2, 0);
        apb(1, 3'd1, 16'h0004);
        tick(1);
        chk("unmask", intr_active, 16'h0004);
        apb(1, 3'd4, 16'h0100);
        apb(0, 3'd2, 0);
        apb(1, 3'd3, 16'h0104);
        apb(0, 3'd2, 0);

        // randomized traffic
        rand_en = 1'b1;
        for (int t = 0; t < 300; t++) begin
            apb(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), 16'($urandom));
            tick($urandom_range(0, 3));
        end
        rand_en = 1'b0;
        tick(1);
        irq_raw = '0; serviced = 1'b0;
        tick(4);

        // reset in the middle of an access
        apb(1, 3'd0, 16'hFFFF);
        apb(1, 3'd1, 16'hFFFF);
        apb(1, 3'd4, 16'hFFFF);
        tick(1);
        chk("all_pend", intr_active, 16'hFFFF);
        psel = 1'b1; penable = 1'b1; pwrite = 1'b0; paddr = 3'd2;
        tick(1);
        #2;
        prst = 1'b1;
        m_clear();
        #1;
        chk("mid_rst_pready", pready, 0);
        chk("mid_rst_active", intr_active, 0);
        chk("mid_rst_prdata", prdata, 0);
        psel = 1'b0; penable = 1'b0;
        tick(1);
        prst = 1'b0;
        tick(1);
        apb(0, 3'd2, 0);
        apb(0, 3'd0, 0);
        tick(2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
